// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: takes a WIDTH-bit word and drives it out on w one
// bit at a time, each bit held DIV cycles, then pulses done for one cycle.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = $clog2(WIDTH);
    localparam logic [DCW-1:0] DIV_MAX = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_MAX = BCW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [DCW-1:0]   div_q, div_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic             w_q, w_d;
    logic             bv_q, bv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // Shift register always holds the bits still to be sent, next one at the head.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        div_d   = div_q;
        bit_d   = bit_q;
        w_d     = w_q;
        bv_d    = bv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                w_d    = 1'b0;
                bv_d   = 1'b0;
                busy_d = 1'b0;
                if (load) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    w_d     = head(data_in);
                    sr_d    = advance(data_in);
                    bv_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (bit_q == BIT_MAX) begin
                        state_d = IDLE;
                        sr_d    = '0;
                        bit_d   = '0;
                        w_d     = 1'b0;
                        bv_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        w_d   = head(sr_q);
                        sr_d  = advance(sr_q);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            w_q     <= 1'b0;
            bv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            w_q     <= w_d;
            bv_q    <= bv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign w         = w_q;
    assign bit_valid = bv_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances cover MSB/DIV=1, MSB/DIV=3
// and LSB/DIV=1; expected streams are written out by hand.
module tb_bit_serializer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] din_a, din_b, din_c;
    logic       load_a, load_b, load_c;
    logic       rdy_a, w_a, bv_a, busy_a, done_a;
    logic       rdy_b, w_b, bv_b, busy_b, done_b;
    logic       rdy_c, w_c, bv_c, busy_c, done_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_a (
        .Clock(Clock), .Reset(Reset), .data_in(din_a), .load(load_a), .ready(rdy_a),
        .w(w_a), .bit_valid(bv_a), .busy(busy_a), .done(done_a));
    bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1)) u_b (
        .Clock(Clock), .Reset(Reset), .data_in(din_b), .load(load_b), .ready(rdy_b),
        .w(w_b), .bit_valid(bv_b), .busy(busy_b), .done(done_b));
    bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u_c (
        .Clock(Clock), .Reset(Reset), .data_in(din_c), .load(load_c), .ready(rdy_c),
        .w(w_c), .bit_valid(bv_c), .busy(busy_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    // Load one word on instance A, then check all 8 bit cycles and the done cycle.
    task automatic send_a(input logic [7:0] d, input string tag);
        din_a = d; load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk({tag, "_w"}, {31'd0, w_a}, {31'd0, d[8-c]});
            chk({tag, "_bv"}, {31'd0, bv_a}, 32'd1);
            chk({tag, "_rdy"}, {31'd0, rdy_a}, 32'd0);
            chk({tag, "_done_early"}, {31'd0, done_a}, 32'd0);
            step();
        end
        chk({tag, "_done"}, {31'd0, done_a}, 32'd1);
        chk({tag, "_done_w"}, {31'd0, w_a}, 32'd0);
        chk({tag, "_done_bv"}, {31'd0, bv_a}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_done_rdy"}, {31'd0, rdy_a}, 32'd1);
        step();
        chk({tag, "_done_pulse"}, {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int bv_cnt;
        Reset = 1'b1;
        din_a = '0; din_b = '0; din_c = '0;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        step(); step();
        chk("rst_w", {31'd0, w_a}, 32'd0);
        chk("rst_bv", {31'd0, bv_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_rdy", {31'd0, rdy_a}, 32'd1);
        Reset = 1'b0;
        step();

        // Basic MSB-first word 11010000.
        send_a(8'b1101_0000, "msb");

        // DIV=3, 8'hA5: each bit held three cycles, done on cycle 25.
        d = 8'hA5;
        din_b = d; load_b = 1'b1;
        step();
        load_b = 1'b0;
        din_b = 8'h00;
        bv_cnt = 0;
        for (int c = 1; c <= 24; c++) begin
            chk("div3_w", {31'd0, w_b}, {31'd0, d[7 - (c-1)/3]});
            chk("div3_done_early", {31'd0, done_b}, 32'd0);
            if (bv_b) bv_cnt++;
            step();
        end
        chk("div3_bv_cycles", bv_cnt, 32'd24);
        chk("div3_done", {31'd0, done_b}, 32'd1);
        chk("div3_done_bv", {31'd0, bv_b}, 32'd0);
        step();
        chk("div3_done_pulse", {31'd0, done_b}, 32'd0);

        // LSB-first 8'h01: single 1 on cycle 1.
        din_c = 8'h01; load_c = 1'b1;
        step();
        load_c = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("lsb_w", {31'd0, w_c}, (c == 1) ? 32'd1 : 32'd0);
            chk("lsb_bv", {31'd0, bv_c}, 32'd1);
            step();
        end
        chk("lsb_done", {31'd0, done_c}, 32'd1);
        step();

        // Load held high with data toggling; second word taken in the done cycle.
        d = 8'hC3;
        din_a = d; load_a = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            din_a = c[0] ? 8'hFF : 8'h00;
            chk("hold_w1", {31'd0, w_a}, {31'd0, d[8-c]});
            chk("hold_bv1", {31'd0, bv_a}, 32'd1);
            step();
        end
        chk("hold_gap_done", {31'd0, done_a}, 32'd1);
        chk("hold_gap_bv", {31'd0, bv_a}, 32'd0);
        chk("hold_gap_w", {31'd0, w_a}, 32'd0);
        chk("hold_gap_rdy", {31'd0, rdy_a}, 32'd1);
        d = 8'h5A;
        din_a = d;
        step();
        load_a = 1'b0;
        din_a = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            chk("hold_w2", {31'd0, w_a}, {31'd0, d[8-c]});
            chk("hold_bv2", {31'd0, bv_a}, 32'd1);
            step();
        end
        chk("hold_done2", {31'd0, done_a}, 32'd1);
        step();

        // Reset during cycle 4 aborts the word with no done pulse.
        din_a = 8'hFF; load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("abort_w", {31'd0, w_a}, 32'd1);
            if (c == 4) Reset = 1'b1;
            step();
        end
        Reset = 1'b0;
        for (int c = 5; c <= 12; c++) begin
            chk("abort_w0", {31'd0, w_a}, 32'd0);
            chk("abort_busy", {31'd0, busy_a}, 32'd0);
            chk("abort_rdy", {31'd0, rdy_a}, 32'd1);
            chk("abort_nodone", {31'd0, done_a}, 32'd0);
            step();
        end
        send_a(8'h81, "after_abort");

        // Reset and load on the same edge: load is dropped.
        Reset = 1'b1; din_a = 8'hFF; load_a = 1'b1;
        step();
        Reset = 1'b0; load_a = 1'b0;
        chk("rstld_busy", {31'd0, busy_a}, 32'd0);
        chk("rstld_bv", {31'd0, bv_a}, 32'd0);
        chk("rstld_w", {31'd0, w_a}, 32'd0);
        chk("rstld_rdy", {31'd0, rdy_a}, 32'd1);
        step();
        chk("rstld_busy2", {31'd0, busy_a}, 32'd0);
        chk("rstld_done", {31'd0, done_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per word (WIDTH >= 2).
REQ-002 Parameter DIV, default 1, clock cycles each serial bit is held (DIV >= 1).
REQ-003 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = LSB first.
REQ-004 Clock  input  1  single clock; all state changes on posedge Clock.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on posedge Clock.
REQ-006 data_in  input  WIDTH  parallel word to serialize.
REQ-007 load  input  1  request to accept data_in.
REQ-008 ready  output  1  high when a load is accepted this cycle.
REQ-009 w  output  1  serial bit stream driven to the downstream sequence detector.
REQ-010 bit_valid  output  1  high while w carries a word bit.
REQ-011 busy  output  1  high while a word is being shifted.
REQ-012 done  output  1  one-cycle pulse after the last bit period of a word.
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs except ready from state.

Function
REQ-014 The block SHALL implement states IDLE and SHIFT; IDLE SHALL be the reset state.
REQ-015 ready SHALL equal 1 in IDLE and 0 in SHIFT.
REQ-016 A load SHALL be accepted on a posedge where load=1 and ready=1; data_in SHALL be captured into an internal shift register at that edge.
REQ-017 On acceptance the block SHALL enter SHIFT; from the next cycle w SHALL present bit 0 of the sequence (data_in[WIDTH-1] if MSB_FIRST=1, else data_in[0]), with bit_valid=1 and busy=1.
REQ-018 Each bit SHALL be held on w for exactly DIV cycles, using a divider counter from 0 to DIV-1.
REQ-019 Bits SHALL follow in order with no gaps; the word occupies exactly WIDTH*DIV consecutive cycles.
REQ-020 A bit counter SHALL track bits sent; after the DIV-th cycle of bit WIDTH-1 the block SHALL return to IDLE.
REQ-021 In the first IDLE cycle after a word, done SHALL be 1 for exactly one cycle; w=0, bit_valid=0, busy=0.
REQ-022 In IDLE w SHALL be 0 and bit_valid SHALL be 0.
REQ-023 load asserted in SHIFT SHALL be ignored and SHALL not affect the current word.
REQ-024 Changes on data_in after acceptance SHALL not affect the transmitted bits.
REQ-025 A load in the done cycle SHALL be accepted (ready=1), giving back-to-back words with a one-cycle w=0 gap.
REQ-026 Counters SHALL be sized to hold DIV-1 and WIDTH-1 without overflow; the divider SHALL not wrap mid-bit.

Reset
REQ-027 On a posedge with Reset=1: state=IDLE, w=0, bit_valid=0, busy=0, done=0, counters=0, shift register=0.
REQ-028 Reset SHALL take priority over load at the same edge; that load SHALL be dropped.
REQ-029 Reset during SHIFT SHALL abort the word with no done pulse; ready=1 from the cycle after the reset edge.

Verification
REQ-030 WIDTH=8, DIV=1, MSB_FIRST=1, load 8'b11010000 at edge 0 -> w=1,1,0,1,0,0,0,0 on cycles 1-8, bit_valid=1 cycles 1-8, done=1 on cycle 9 only.
REQ-031 DIV=3, load 8'hA5 -> each bit held 3 cycles, 24 bit_valid cycles, done on cycle 25.
REQ-032 MSB_FIRST=0, load 8'h01 -> w=1 on cycle 1, then 0 for cycles 2-8.
REQ-033 load held high during SHIFT with data_in toggling -> only the first word is sent, second word accepted in the done cycle, w=0 for exactly that one cycle between words.
REQ-034 Reset asserted at cycle 4 of a word -> w=0, busy=0, ready=1 from cycle 5; no done pulse; a subsequent load transmits normally.
REQ-035 Reset and load together -> load ignored, outputs held at reset values.
